// File: rtl/memory_bank.sv
// DEPTH x DATA_W register store: one synchronous write port, two registered read ports,
// and a one-word-per-cycle clear engine. Define MEMORY_BANK_BYPASS_EN for write-first reads.
module memory_bank #(
   parameter int                 DATA_W    = 16,
   parameter int                 ADDR_W    = 4,
   parameter logic [DATA_W-1:0]  CLR_VALUE = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              clr_req,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   output logic              busy,
   output logic              clr_done
);
   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              user_wr;
   logic [DATA_W-1:0] rd1, rd2;

   // A clear request in IDLE takes priority over a same-cycle user write.
   assign user_wr = we && ((state == DONE) || (state == IDLE && !clr_req));

`ifdef MEMORY_BANK_BYPASS_EN
   assign rd1 = (user_wr && raddr1 == waddr) ? wdata : mem[raddr1];
   assign rd2 = (user_wr && raddr2 == waddr) ? wdata : mem[raddr2];
`else
   assign rd1 = mem[raddr1];
   assign rd2 = mem[raddr2];
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= CLEAR;
         ptr      <= '0;
         busy     <= 1'b1;
         clr_done <= 1'b0;
         rdata1   <= '0;
         rdata2   <= '0;
      end else begin
         if (state == CLEAR) begin
            rdata1 <= CLR_VALUE;
            rdata2 <= CLR_VALUE;
         end else begin
            rdata1 <= rd1;
            rdata2 <= rd2;
         end
         if (user_wr)
            mem[waddr] <= wdata;
         case (state)
            IDLE: begin
               clr_done <= 1'b0;
               if (clr_req) begin
                  state <= CLEAR;
                  ptr   <= '0;
                  busy  <= 1'b1;
               end
            end
            CLEAR: begin
               mem[ptr] <= CLR_VALUE;
               ptr      <= ptr + 1'b1;
               // Last word written this cycle; pointer wraps back to 0 on its own.
               if (ptr == {ADDR_W{1'b1}}) begin
                  state    <= DONE;
                  busy     <= 1'b0;
                  clr_done <= 1'b1;
               end
            end
            DONE: begin
               state    <= IDLE;
               busy     <= 1'b0;
               clr_done <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               busy     <= 1'b0;
               clr_done <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_memory_bank.sv
// Directed bench for memory_bank; a second instance uses CLR_VALUE=0x00FF.
module tb_memory_bank;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        we;
   logic [3:0]  waddr;
   logic [15:0] wdata;
   logic        clr_req;
   logic [3:0]  raddr1, raddr2;
   logic [15:0] rdata1, rdata2, rdata1_b, rdata2_b;
   logic        busy, clr_done, busy_b, clr_done_b;
   int total = 0;
   int bad   = 0;

   memory_bank dut (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .clr_req(clr_req), .raddr1(raddr1), .raddr2(raddr2),
      .rdata1(rdata1), .rdata2(rdata2), .busy(busy), .clr_done(clr_done)
   );

   memory_bank #(.CLR_VALUE(16'h00FF)) dut_ff (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
      .clr_req(clr_req), .raddr1(raddr1), .raddr2(raddr2),
      .rdata1(rdata1_b), .rdata2(rdata2_b), .busy(busy_b), .clr_done(clr_done_b)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d);
      we = 1'b1; waddr = a; wdata = d;
      tick();
      we = 1'b0;
   endtask

   task automatic fill(input logic [15:0] d);
      for (int a = 0; a < 16; a++) wr(4'(a), d);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; clr_req = 1'b0;
      raddr1 = '0; raddr2 = '0;
      tick(); tick();
      total++;
      if (rdata1 !== 16'h0 || rdata2 !== 16'h0 || busy !== 1'b1 || clr_done !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: rd1=%h rd2=%h busy=%b done=%b want 0 0 1 0",
                  rdata1, rdata2, busy, clr_done);
      end
   endtask

   task automatic test_post_reset_sweep();
      int n = 0;
      rst_n = 1'b1;
      while (busy === 1'b1 && n < 40) begin n++; tick(); end
      total++;
      if (n !== 16 || clr_done !== 1'b1) begin
         bad++;
         $display("FAIL reset_sweep_len: busy_cycles=%0d done=%b want 16 1", n, clr_done);
      end
      tick();
      total++;
      if (clr_done !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_done_pulse: done=%b busy=%b want 0 0", clr_done, busy);
      end
      for (int a = 0; a < 16; a++) begin
         raddr1 = 4'(a); raddr2 = 4'(15 - a);
         tick();
         total++;
         if (rdata1 !== 16'h0 || rdata2 !== 16'h0) begin
            bad++;
            $display("FAIL reset_readback a=%0d: rd1=%h rd2=%h want 0000", a, rdata1, rdata2);
         end
      end
   endtask

   task automatic test_write_read();
      wr(4'd3, 16'hA5A5);
      wr(4'd15, 16'h1234);
      raddr1 = 4'd3; raddr2 = 4'd15;
      tick();
      total++;
      if (rdata1 !== 16'hA5A5 || rdata2 !== 16'h1234) begin
         bad++;
         $display("FAIL basic_rw: rd1=%h rd2=%h want a5a5 1234", rdata1, rdata2);
      end
      raddr1 = 4'd15; raddr2 = 4'd15;
      tick();
      total++;
      if (rdata1 !== 16'h1234 || rdata2 !== 16'h1234) begin
         bad++;
         $display("FAIL same_addr: rd1=%h rd2=%h want 1234 1234", rdata1, rdata2);
      end
   endtask

   task automatic test_bypass();
      logic [15:0] exp;
`ifdef MEMORY_BANK_BYPASS_EN
      exp = 16'hBEEF;
`else
      exp = 16'h1111;
`endif
      wr(4'd7, 16'h1111);
      raddr1 = 4'd7; raddr2 = 4'd3;
      wr(4'd7, 16'hBEEF);
      total++;
      if (rdata1 !== exp || rdata2 !== 16'hA5A5) begin
         bad++;
         $display("FAIL same_cycle_rw: rd1=%h rd2=%h want %h a5a5", rdata1, rdata2, exp);
      end
      tick();
      total++;
      if (rdata1 !== 16'hBEEF) begin
         bad++;
         $display("FAIL after_rw: rd1=%h want beef", rdata1);
      end
   endtask

   task automatic test_clear_collision();
      int n = 0;
      fill(16'hFFFF);
      clr_req = 1'b1; we = 1'b1; waddr = 4'd2; wdata = 16'h5555;
      raddr1 = 4'd15; raddr2 = 4'd2;
      tick();
      clr_req = 1'b0; we = 1'b0;
      while (busy === 1'b1 && n < 40) begin
         clr_req = (n == 5);
         we = (n == 12); waddr = 4'd9; wdata = 16'h7777;
         if (n == 3) begin
            total++;
            if (rdata1 !== 16'h0 || rdata2 !== 16'h0) begin
               bad++;
               $display("FAIL sweep_read_override: rd1=%h rd2=%h want 0000", rdata1, rdata2);
            end
         end
         n++;
         tick();
      end
      clr_req = 1'b0; we = 1'b0;
      total++;
      if (n !== 16 || clr_done !== 1'b1) begin
         bad++;
         $display("FAIL clear_len: busy_cycles=%0d done=%b want 16 1", n, clr_done);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (busy !== 1'b0 || clr_done !== 1'b0) begin
            bad++;
            $display("FAIL no_second_sweep i=%0d: busy=%b done=%b want 0 0", i, busy, clr_done);
         end
      end
      for (int a = 0; a < 16; a++) begin
         raddr1 = 4'(a); raddr2 = 4'(a);
         tick();
         total++;
         if (rdata1 !== 16'h0 || rdata2 !== 16'h0) begin
            bad++;
            $display("FAIL clear_readback a=%0d: rd1=%h rd2=%h want 0000", a, rdata1, rdata2);
         end
      end
   endtask

   task automatic test_reset_mid_sweep();
      int n = 0;
      int dones = 0;
      fill(16'hFFFF);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      while (busy === 1'b1 && n < 40) begin n++; tick(); end
      total++;
      if (n !== 16 || clr_done !== 1'b1 || busy_b !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset_len: busy_cycles=%0d done=%b want 16 1", n, clr_done);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         if (clr_done === 1'b1) dones++;
      end
      total++;
      if (dones !== 0) begin
         bad++;
         $display("FAIL mid_reset_done_once: extra_pulses=%0d want 0", dones);
      end
      for (int a = 0; a < 16; a++) begin
         raddr1 = 4'(a); raddr2 = 4'(15 - a);
         tick();
         total++;
         if (rdata1_b !== 16'h00FF || rdata2_b !== 16'h00FF || rdata1 !== 16'h0) begin
            bad++;
            $display("FAIL clr_value_readback a=%0d: rd1=%h rd2=%h base=%h want 00ff 00ff 0000",
                     a, rdata1_b, rdata2_b, rdata1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_post_reset_sweep();
      test_write_read();
      test_bypass();
      test_clear_collision();
      test_reset_mid_sweep();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
